i2c_calc_ctrl: RTL and testbench
================================

# i2c_calc_ctrl

Command sequencer for the I2C calculator. Sits between the I2C target's byte interface and the calculator ALU. Collects an opcode and two operands from an I2C write transaction, launches the ALU with a start/done handshake, and latches the result and status. Serves the status and result bytes back on I2C reads.

## Interface
Clocking: one clock; reset is asynchronous and active-high.

Parameters:
- `TIMEOUT`, default 255: maximum ALU busy cycles before the controller aborts. Width is 8 bits.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `txn_start`  in  1  one-cycle pulse: START or repeated START addressed to this target.
- `txn_stop`  in  1  one-cycle pulse: STOP.
- `rx_valid`  in  1  write byte available.
- `rx_data`  in  8  write byte.
- `rx_ready`  out  1  byte accepted when `rx_valid & rx_ready`. When low, the target NACKs.
- `tx_req`  in  1  one-cycle pulse: the target needs the next read byte.
- `tx_valid`  out  1  one-cycle pulse, one cycle after `tx_req`.
- `tx_data`  out  8  read byte. Qualified by `tx_valid`.
- `alu_start`  out  1  one-cycle launch pulse.
- `alu_op`  out  3  opcode.
- `alu_a`  out  8  first operand.
- `alu_b`  out  8  second operand.
- `alu_done`  in  1  one-cycle pulse: `alu_result` is valid.
- `alu_err`  in  1  one-cycle pulse: the operation failed.
- `alu_result`  in  16  result.
- `busy`  out  1  high in states ISSUE and WAIT.
- `irq`  out  1  level: a new status is available.

## Operation
- States:
  - IDLE: collect write bytes.
  - ISSUE: one cycle, `alu_start` = 1.
  - WAIT: wait for the ALU.
- Write byte index `widx` (2 bits, saturating at 3):
  - Reset to 0 on `txn_start`.
  - Index 0 → `op_q`, 1 → `a_q`, 2 → `b_q`.
  - Bytes at index ≥ 3 are accepted and discarded, and set `ovf_q`.
- `txn_stop` in IDLE, evaluated after any same-cycle byte:
  - `widx`=0: no action.
  - `widx` = 1 or 2: status SHORT, `irq` set, no launch.
  - `widx` ≥ 3 and `op_q` > 5: status BADOP, `irq` set, no launch.
  - Otherwise: go to ISSUE, then WAIT.
- Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR.
- `alu_op`, `alu_a`, `alu_b` are driven from `op_q`, `a_q`, `b_q`. They are held stable from ISSUE until leaving WAIT.
- WAIT exit, then IDLE, with `irq` set:
  - `alu_done`: latch `alu_result`, status OK, result-valid = 1.
  - `alu_err`: status ALU_ERR, result-valid = 0, previous result kept.
  - If both fire in the same cycle, `alu_err` wins.
- `rx_ready` = 1 in IDLE, 0 in ISSUE and WAIT.
- A `txn_start` during ISSUE/WAIT resets only the read pointer. Write bytes are refused.
- Read pointer `ridx` (0..2):
  - Reset to 0 on `txn_start`.
  - Each `tx_req` returns byte[`ridx`], then `ridx` increments, wrapping 2 → 0.
  - Byte 0 = status, byte 1 = result[15:8], byte 2 = result[7:0].
- Status byte layout:
  - [7] busy (live value).
  - [6] result valid.
  - [3] `ovf_q`.
  - [2:0] code: 0 OK, 1 SHORT, 2 BADOP, 3 ALU_ERR, 4 TIMEOUT.
- Reading byte 0 clears `irq`. If an `irq` set event occurs in the same cycle, the set wins.
- `ovf_q` clears when the next launch is issued.
- `alu_done`/`alu_err` outside WAIT are ignored.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0, except `rx_ready` = 1.
  - Registers, `widx`, `ridx`, status and result all 0.
- `txn_stop` sampled in cycle N: ISSUE in N+1 (`alu_start` high), WAIT in N+2.
- `alu_done` in cycle M: result, status and `irq` visible in M+1; state IDLE in M+1.
- `tx_req` in cycle K: `tx_valid` and `tx_data` in K+1. Back-to-back requests are supported every cycle.
- Simultaneous `txn_start` and `rx_valid`: the start is applied first, and the byte is stored at index 0.
- Reset mid-WAIT: return to IDLE immediately, `busy` = 0. A late `alu_done` is then ignored.

## Configuration
Macro: `CALC_TIMEOUT_EN`.
- Defined:
  - WAIT counts cycles from entry.
  - Reaching `TIMEOUT` cycles without `alu_done`/`alu_err` → status TIMEOUT, `irq` set, IDLE.
  - `alu_done` in the same cycle as expiry wins.
- Undefined:
  - WAIT waits indefinitely.
  - Code 4 is never produced.
  - `TIMEOUT` is unused.

## Structure
- Package `calc_pkg` contains:
  - Opcode enum.
  - State enum (IDLE/ISSUE/WAIT).
  - Status code constants.
  - Read byte index constants.
  - Status bit positions.
- Sub-module `calc_watchdog`:
  - 8-bit counter with clear and enable, and an `expired` output.
  - Instantiated only under `CALC_TIMEOUT_EN`.

## Test plan
- Write 0x02, 0x10, 0x20, STOP; ALU returns 0x0200 after 5 cycles → `alu_start` at stop+1, `alu_a`=0x10, `alu_b`=0x20; read returns 0x40, 0x02, 0x00; `irq` clears after the first read byte.
- Write 0x00, 0x05, STOP → no `alu_start`; status read is 0x01.
- Write 0x07, 1, 2, STOP → status 0x02, no launch. Write 0, 1, 2, 3, 4, STOP → launch with `alu_a`=1, `alu_b`=2; status has bit3 set.
- During WAIT, a write attempt → `rx_ready`=0; a status read → bit7=1. Assert `alu_err` → status 0x03, `busy` = 0.
- With `CALC_TIMEOUT_EN` and `TIMEOUT`=10, the ALU never responds → status 0x04 exactly 10 cycles after WAIT entry.
- Assert `rst` two cycles into WAIT, then pulse `alu_done` → outputs return to reset values; the result stays 0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the I2C calculator command sequencer.
// Compile-time option: CALC_TIMEOUT_EN (enables the ALU busy watchdog).
package calc_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    localparam logic [2:0] CODE_OK      = 3'd0;
    localparam logic [2:0] CODE_SHORT   = 3'd1;
    localparam logic [2:0] CODE_BADOP   = 3'd2;
    localparam logic [2:0] CODE_ALU_ERR = 3'd3;
    localparam logic [2:0] CODE_TIMEOUT = 3'd4;

    localparam logic [1:0] RB_STATUS = 2'd0;
    localparam logic [1:0] RB_RES_HI = 2'd1;
    localparam logic [1:0] RB_RES_LO = 2'd2;

    localparam int SB_BUSY   = 7;
    localparam int SB_RVALID = 6;
    localparam int SB_OVF    = 3;

    function automatic logic [7:0] status_byte(input logic       busy,
                                               input logic       rvalid,
                                               input logic       ovf,
                                               input logic [2:0] code);
        logic [7:0] s;
        s            = '0;
        s[SB_BUSY]   = busy;
        s[SB_RVALID] = rvalid;
        s[SB_OVF]    = ovf;
        s[2:0]       = code;
        return s;
    endfunction

endpackage

// File: rtl/calc_watchdog.sv
// ALU busy watchdog: down-counter loaded with LIMIT-1 while cleared,
// terminal count flags expiry. Only built when CALC_TIMEOUT_EN is defined.
module calc_watchdog #(
    parameter logic [7:0] LIMIT = 8'd255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    logic [7:0] r_cnt;

    // Reload on clear, count down toward zero while enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (i_clear) begin
            r_cnt <= LIMIT - 8'd1;
        end else if (i_en && (r_cnt != 8'd0)) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_expired = i_en && (r_cnt == 8'd0);

endmodule

// File: rtl/i2c_calc_ctrl.sv
// Command sequencer between the I2C target byte interface and the ALU.
// Optional feature: CALC_TIMEOUT_EN adds a WAIT watchdog (TIMEOUT cycles).
//
// state   | meaning
// --------+------------------------------------------------
// S_IDLE  | accept write bytes, act on STOP
// S_ISSUE | one cycle, alu_start asserted
// S_WAIT  | wait for alu_done / alu_err (or watchdog expiry)
module i2c_calc_ctrl
    import calc_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        txn_start,
    input  logic        txn_stop,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        tx_req,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        alu_start,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic        alu_done,
    input  logic        alu_err,
    input  logic [15:0] alu_result,
    output logic        busy,
    output logic        irq
);

    state_e      r_state, w_state_nxt;
    logic [1:0]  r_widx, w_widx_eff, w_widx_after;
    logic [7:0]  r_op_q, r_a_q, r_b_q, w_op_after;
    logic        r_ovf_q, r_ovf_cur;
    logic [2:0]  r_code;
    logic        r_rvalid, r_irq;
    logic [15:0] r_result;
    logic [1:0]  r_ridx, w_ridx_eff;
    logic        r_tx_valid;
    logic [7:0]  r_tx_data, w_tx_byte, w_status;
    logic        w_wr_en, w_start_idle, w_ovf_byte, w_expired;
    logic        w_rx_ready, w_alu_start, w_busy, w_launch;
    logic        w_fin_short, w_fin_badop, w_fin_done, w_fin_err, w_fin_tmo;
    logic        w_irq_set;

    // Write path view of the current cycle: a same-cycle START rewinds first.
    assign w_wr_en      = rx_valid && (r_state == S_IDLE);
    assign w_start_idle = txn_start && (r_state == S_IDLE);
    assign w_widx_eff   = w_start_idle ? 2'd0 : r_widx;
    assign w_widx_after = !w_wr_en ? w_widx_eff :
                          (w_widx_eff == 2'd3) ? 2'd3 : w_widx_eff + 2'd1;
    assign w_op_after   = (w_wr_en && (w_widx_eff == 2'd0)) ? rx_data : r_op_q;
    assign w_ovf_byte   = w_wr_en && (w_widx_eff == 2'd3);

`ifdef CALC_TIMEOUT_EN
    calc_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (r_state != S_WAIT),
        .i_en      (r_state == S_WAIT),
        .o_expired (w_expired)
    );
`else
    // Without the watchdog WAIT never expires.
    assign w_expired = 1'b0 && (TIMEOUT != 8'd0);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state, handshake outputs and completion events.
    always_comb begin
        w_state_nxt = r_state;
        w_rx_ready  = 1'b0;
        w_alu_start = 1'b0;
        w_busy      = 1'b0;
        w_launch    = 1'b0;
        w_fin_short = 1'b0;
        w_fin_badop = 1'b0;
        w_fin_done  = 1'b0;
        w_fin_err   = 1'b0;
        w_fin_tmo   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_rx_ready = 1'b1;
                if (txn_stop) begin
                    if ((w_widx_after == 2'd1) || (w_widx_after == 2'd2)) begin
                        w_fin_short = 1'b1;
                    end else if (w_widx_after == 2'd3) begin
                        if (w_op_after > 8'(OP_XOR)) begin
                            w_fin_badop = 1'b1;
                        end else begin
                            w_launch    = 1'b1;
                            w_state_nxt = S_ISSUE;
                        end
                    end
                end
            end
            S_ISSUE: begin
                w_alu_start = 1'b1;
                w_busy      = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_busy = 1'b1;
                if (alu_err) begin
                    w_fin_err   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (alu_done) begin
                    w_fin_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_expired) begin
                    w_fin_tmo   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Command capture. ovf_q keeps the overflow of the command being launched
    // but drops overflows left over from earlier transactions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_widx    <= 2'd0;
            r_op_q    <= 8'd0;
            r_a_q     <= 8'd0;
            r_b_q     <= 8'd0;
            r_ovf_q   <= 1'b0;
            r_ovf_cur <= 1'b0;
        end else begin
            r_widx <= w_widx_after;
            if (w_wr_en) begin
                case (w_widx_eff)
                    2'd0:    r_op_q <= rx_data;
                    2'd1:    r_a_q  <= rx_data;
                    2'd2:    r_b_q  <= rx_data;
                    default: ;
                endcase
            end
            if (w_start_idle)    r_ovf_cur <= 1'b0;
            else if (w_ovf_byte) r_ovf_cur <= 1'b1;
            if (w_launch)        r_ovf_q <= r_ovf_cur || w_ovf_byte;
            else if (w_ovf_byte) r_ovf_q <= 1'b1;
        end
    end

    assign w_irq_set  = w_fin_short || w_fin_badop || w_fin_done || w_fin_err || w_fin_tmo;
    assign w_ridx_eff = txn_start ? RB_STATUS : r_ridx;

    // Status, result and interrupt; a same-cycle set beats the read-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code   <= CODE_OK;
            r_rvalid <= 1'b0;
            r_result <= 16'd0;
            r_irq    <= 1'b0;
        end else begin
            if (w_fin_err) begin
                r_code   <= CODE_ALU_ERR;
                r_rvalid <= 1'b0;
            end else if (w_fin_done) begin
                r_code   <= CODE_OK;
                r_rvalid <= 1'b1;
                r_result <= alu_result;
            end else if (w_fin_tmo) begin
                r_code <= CODE_TIMEOUT;
            end else if (w_fin_badop) begin
                r_code <= CODE_BADOP;
            end else if (w_fin_short) begin
                r_code <= CODE_SHORT;
            end
            if (w_irq_set)                                 r_irq <= 1'b1;
            else if (tx_req && (w_ridx_eff == RB_STATUS))  r_irq <= 1'b0;
        end
    end

    assign w_status = status_byte(w_busy, r_rvalid, r_ovf_q, r_code);

    // Read byte selection.
    always_comb begin
        w_tx_byte = w_status;
        case (w_ridx_eff)
            RB_RES_HI: w_tx_byte = r_result[15:8];
            RB_RES_LO: w_tx_byte = r_result[7:0];
            default:   w_tx_byte = w_status;
        endcase
    end

    // Read pointer and registered read byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ridx     <= RB_STATUS;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'd0;
        end else begin
            r_tx_valid <= tx_req;
            if (tx_req) begin
                r_tx_data <= w_tx_byte;
                r_ridx    <= (w_ridx_eff == RB_RES_LO) ? RB_STATUS : w_ridx_eff + 2'd1;
            end else if (txn_start) begin
                r_ridx <= RB_STATUS;
            end
        end
    end

    assign rx_ready  = w_rx_ready;
    assign alu_start = w_alu_start;
    assign busy      = w_busy;
    assign irq       = r_irq;
    assign tx_valid  = r_tx_valid;
    assign tx_data   = r_tx_data;
    assign alu_op    = r_op_q[2:0];
    assign alu_a     = r_a_q;
    assign alu_b     = r_b_q;

endmodule

// File: tb/tb_i2c_calc_ctrl.sv
// Self-checking bench for i2c_calc_ctrl: directed scenarios plus randomized
// commands, checked against a transaction-level reference model.
module tb_i2c_calc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        txn_start = 1'b0, txn_stop = 1'b0, rx_valid = 1'b0, tx_req = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        alu_done = 1'b0, alu_err = 1'b0;
    logic [15:0] alu_result = 16'd0;
    logic        rx_ready, tx_valid, alu_start, busy, irq;
    logic [7:0]  tx_data, alu_a, alu_b;
    logic [2:0]  alu_op;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bytes of the current write transaction plus visible status.
    logic [7:0]  q[$];
    logic [2:0]  m_code;
    bit          m_rvalid, m_ovf, m_irq, m_busy;
    logic [15:0] m_result;
    int          m_ridx;
    logic [2:0]  m_lop;
    logic [7:0]  m_la, m_lb;

    i2c_calc_ctrl #(.TIMEOUT(8'd10)) dut (
        .clk(clk), .rst(rst), .txn_start(txn_start), .txn_stop(txn_stop),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_req(tx_req), .tx_valid(tx_valid), .tx_data(tx_data),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_err(alu_err), .alu_result(alu_result),
        .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] calc(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return 16'(a) + 16'(b);
            3'd1:    return 16'(a) - 16'(b);
            3'd2:    return 16'(a) * 16'(b);
            3'd3:    return {8'd0, a & b};
            3'd4:    return {8'd0, a | b};
            default: return {8'd0, a ^ b};
        endcase
    endfunction

    function automatic logic [7:0] m_status();
        return {m_busy, m_rvalid, 2'b00, m_ovf, m_code};
    endfunction

    task automatic model_reset();
        q.delete();
        m_code = 3'd0; m_rvalid = 0; m_ovf = 0; m_irq = 0; m_busy = 0;
        m_result = 16'd0; m_ridx = 0;
        m_lop = 3'd0; m_la = 8'd0; m_lb = 8'd0;
    endtask

    task automatic do_start();
        txn_start = 1'b1;
        cyc();
        txn_start = 1'b0;
        m_ridx = 0;
        if (!m_busy) q.delete();
    endtask

    task automatic do_byte(input logic [7:0] b, input bit with_start);
        txn_start = with_start;
        rx_valid  = 1'b1;
        rx_data   = b;
        #1;
        chk("rx_ready", 16'(rx_ready), 16'(!m_busy));
        cyc();
        txn_start = 1'b0;
        rx_valid  = 1'b0;
        if (with_start) begin
            m_ridx = 0;
            if (!m_busy) q.delete();
        end
        if (!m_busy) begin
            q.push_back(b);
            if (q.size() > 3) m_ovf = 1;
        end
    endtask

    // Returns whether a launch was expected.
    task automatic do_stop(output bit launched);
        int n;
        n = q.size();
        launched = 0;
        txn_stop = 1'b1;
        cyc();
        txn_stop = 1'b0;
        if (!m_busy) begin
            if (n == 1 || n == 2) begin
                m_code = 3'd1; m_irq = 1;
            end else if (n >= 3 && q[0] > 8'd5) begin
                m_code = 3'd2; m_irq = 1;
            end else if (n >= 3) begin
                launched = 1;
                m_busy = 1;
                m_ovf  = (n > 3);
                m_lop  = q[0][2:0];
                m_la   = q[1];
                m_lb   = q[2];
            end
        end
        chk("stop_alu_start", 16'(alu_start), 16'(launched));
        chk("stop_busy", 16'(busy), 16'(m_busy));
        chk("stop_irq", 16'(irq), 16'(m_irq));
        if (launched) begin
            chk("launch_op", 16'(alu_op), 16'(m_lop));
            chk("launch_a", 16'(alu_a), 16'(m_la));
            chk("launch_b", 16'(alu_b), 16'(m_lb));
        end
    endtask

    task automatic enter_wait();
        cyc();
        chk("wait_alu_start", 16'(alu_start), 16'(0));
        chk("wait_busy", 16'(busy), 16'(1));
        chk("wait_a_held", 16'(alu_a), 16'(m_la));
        chk("wait_b_held", 16'(alu_b), 16'(m_lb));
    endtask

    // kind: 0 done, 1 err, 2 both
    task automatic respond(input int lat, input int kind);
        logic [15:0] r;
        repeat (lat) cyc();
        chk("pre_resp_busy", 16'(busy), 16'(1));
        r = calc(m_lop, m_la, m_lb);
        alu_result = r;
        alu_done = (kind != 1);
        alu_err  = (kind != 0);
        cyc();
        alu_done = 1'b0;
        alu_err  = 1'b0;
        m_busy = 0;
        m_irq  = 1;
        if (kind != 0) begin
            m_code = 3'd3; m_rvalid = 0;
        end else begin
            m_code = 3'd0; m_rvalid = 1; m_result = r;
        end
        chk("resp_busy", 16'(busy), 16'(0));
        chk("resp_irq", 16'(irq), 16'(1));
        chk("resp_rx_ready", 16'(rx_ready), 16'(1));
    endtask

    task automatic rd(input string tag);
        logic [7:0] e;
        case (m_ridx)
            0:       e = m_status();
            1:       e = m_result[15:8];
            default: e = m_result[7:0];
        endcase
        tx_req = 1'b1;
        cyc();
        tx_req = 1'b0;
        if (m_ridx == 0) m_irq = 0;
        m_ridx = (m_ridx + 1) % 3;
        chk({tag, "_txv"}, 16'(tx_valid), 16'(1));
        chk(tag, 16'(tx_data), 16'(e));
        chk({tag, "_irq"}, 16'(irq), 16'(m_irq));
    endtask

    task automatic write_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int n);
        logic [7:0] bytes[5];
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = 8'h03; bytes[4] = 8'h04;
        for (int i = 0; i < n; i++) do_byte(bytes[i], 1'b0);
    endtask

    initial begin
        bit l;
        int n, lat, kind;
        logic [7:0] b0, b1, b2;

        model_reset();
        cyc(); cyc();
        chk("rst_rx_ready", 16'(rx_ready), 16'(1));
        chk("rst_busy", 16'(busy), 16'(0));
        chk("rst_alu_start", 16'(alu_start), 16'(0));
        chk("rst_irq", 16'(irq), 16'(0));
        chk("rst_tx_valid", 16'(tx_valid), 16'(0));
        chk("rst_alu_ab", {alu_a, alu_b}, 16'(0));
        rst = 1'b0;
        cyc();

        // Short command.
        do_start();
        write_cmd(8'h00, 8'h05, 8'h00, 2);
        do_stop(l);
        do_start();
        rd("short_status");
        chk("short_model", 16'(m_code), 16'(1));

        // Bad opcode.
        do_start();
        write_cmd(8'h07, 8'h01, 8'h02, 3);
        do_stop(l);
        do_start();
        rd("badop_status");

        // Main flow: 0x02, 0x10, 0x20; result 0x0200 after 5 cycles.
        do_start();
        write_cmd(8'h02, 8'h10, 8'h20, 3);
        do_stop(l);
        enter_wait();
        respond(5, 0);
        do_start();
        rd("main_status");
        rd("main_hi");
        rd("main_lo");

        // Overflow bytes still launch; status reports bit 3.
        do_start();
        write_cmd(8'h00, 8'h01, 8'h02, 5);
        do_stop(l);
        enter_wait();
        respond(2, 0);
        do_start();
        rd("ovf_status");

        // Busy behaviour and ALU error.
        do_start();
        write_cmd(8'h03, 8'h0F, 8'h33, 3);
        do_stop(l);
        enter_wait();
        do_byte(8'h55, 1'b0);
        do_start();
        rd("busy_status");
        respond(1, 1);
        rd("err_hi");
        rd("err_lo");
        rd("err_status");

        // Randomized commands.
        for (int it = 0; it < 24; it++) begin
            n  = $urandom_range(0, 5);
            b0 = (it % 5 == 0) ? 8'($urandom_range(6, 255)) : 8'($urandom_range(0, 7));
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            if (n > 0 && $urandom_range(0, 1) == 1) begin
                do_byte(b0, 1'b1);
                if (n > 1) do_byte(b1, 1'b0);
                if (n > 2) do_byte(b2, 1'b0);
                for (int k = 3; k < n; k++) do_byte(8'($urandom), 1'b0);
            end else begin
                do_start();
                write_cmd(b0, b1, b2, n);
            end
            do_stop(l);
            if (l) begin
                lat  = $urandom_range(0, 6);
                kind = $urandom_range(0, 2);
                enter_wait();
                respond(lat, kind);
            end
            if ($urandom_range(0, 3) == 0) begin
                alu_done = 1'b1;
                alu_result = 16'($urandom);
                cyc();
                alu_done = 1'b0;
                chk("idle_done_ignored", 16'(busy), 16'(0));
            end
            do_start();
            for (int r = 0; r < 3 + 3 * (it % 2); r++) rd("rand_read");
        end

`ifdef CALC_TIMEOUT_EN
        // Watchdog: no ALU response, TIMEOUT = 10 cycles after WAIT entry.
        do_start();
        write_cmd(8'h04, 8'h21, 8'h07, 3);
        do_stop(l);
        enter_wait();
        repeat (9) cyc();
        chk("tmo_still_busy", 16'(busy), 16'(1));
        cyc();
        chk("tmo_busy", 16'(busy), 16'(0));
        chk("tmo_irq", 16'(irq), 16'(1));
        m_busy = 0; m_irq = 1; m_code = 3'd4;
        do_start();
        rd("tmo_status");
`else
        // Without the watchdog WAIT holds indefinitely.
        do_start();
        write_cmd(8'h04, 8'h21, 8'h07, 3);
        do_stop(l);
        enter_wait();
        repeat (40) cyc();
        chk("nowdog_busy", 16'(busy), 16'(1));
        respond(0, 0);
        do_start();
        rd("nowdog_status");
`endif

        // Reset two cycles into WAIT, then a late alu_done.
        do_start();
        write_cmd(8'h02, 8'h0A, 8'h0B, 3);
        do_stop(l);
        enter_wait();
        cyc(); cyc();
        rst = 1'b1;
        #1;
        model_reset();
        chk("mrst_busy", 16'(busy), 16'(0));
        chk("mrst_rx_ready", 16'(rx_ready), 16'(1));
        chk("mrst_irq", 16'(irq), 16'(0));
        chk("mrst_alu", {5'd0, alu_op, alu_a}, 16'(0));
        chk("mrst_alu_b", 16'(alu_b), 16'(0));
        cyc();
        rst = 1'b0;
        alu_done = 1'b1;
        alu_result = 16'hBEEF;
        cyc();
        alu_done = 1'b0;
        chk("late_done_busy", 16'(busy), 16'(0));
        chk("late_done_irq", 16'(irq), 16'(0));
        rd("mrst_status");
        rd("mrst_hi");
        rd("mrst_lo");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
